// File: rtl/tdc_spi_master_burst.sv
// SPI master for the TDC register/result port.
// Configurable word width, SPI mode, CS timing, CS-held bursts and abort.
module tdc_spi_master_burst #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cs_hold,
  input  logic              abort,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CM1 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CMAX = (CM1 > CS_IDLE) ? CM1 : CS_IDLE;
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     ph;
  logic [BW-1:0]     bitn;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] rx;
  logic              hold_q;
  logic              ph_mid;
  logic              ph_end;
  logic              last;

  assign ph_mid = (ph == PW'(HALF - 1));
  assign ph_end = (ph == PW'(CLK_DIV - 1));
  assign last   = (bitn == BW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cs_n       <= 1'b1;
      sck        <= CPOL;
      mosi       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      ph         <= '0;
      bitn       <= '0;
      tx         <= '0;
      rx         <= '0;
      hold_q     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (abort) begin
            if (!cs_n) begin
              state <= HOLD;
              cnt   <= CW'(CS_HOLD - 1);
              busy  <= 1'b1;
            end
          end else if (start) begin
            busy   <= 1'b1;
            hold_q <= cs_hold;
            tx     <= data_in;
            ph     <= '0;
            bitn   <= '0;
            // MSB goes out now unless CPHA=1 defers it to the first leading edge
            if (!CPHA || !cs_n) begin
              mosi <= data_in[DATA_W-1];
              tx   <= data_in << 1;
            end
            if (cs_n) begin
              cs_n  <= 1'b0;
              state <= SETUP;
              cnt   <= CW'(CS_SETUP - 1);
            end else begin
              state <= SHIFT;
              sck   <= ~CPOL;
            end
          end
        end
        SETUP: begin
          if (abort) begin
            state <= HOLD;
            cnt   <= CW'(CS_HOLD - 1);
            sck   <= CPOL;
          end else if (cnt == '0) begin
            state <= SHIFT;
            sck   <= ~CPOL;
            if (CPHA) begin
              mosi <= tx[DATA_W-1];
              tx   <= tx << 1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= HOLD;
            cnt   <= CW'(CS_HOLD - 1);
            sck   <= CPOL;
          end else if (ph_mid) begin
            sck <= CPOL;
            rx  <= {rx[DATA_W-2:0], miso};
            ph  <= ph + 1'b1;
            if (!CPHA) begin
              mosi <= tx[DATA_W-1];
              tx   <= tx << 1;
            end
          end else if (ph_end) begin
            ph <= '0;
            if (last) begin
              data_out   <= rx;
              data_valid <= 1'b1;
              if (hold_q) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= HOLD;
                cnt   <= CW'(CS_HOLD - 1);
              end
            end else begin
              bitn <= bitn + 1'b1;
              sck  <= ~CPOL;
              if (CPHA) begin
                mosi <= tx[DATA_W-1];
                tx   <= tx << 1;
              end
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cs_n  <= 1'b1;
            state <= GAP;
            cnt   <= CW'(CS_IDLE - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdc_spi_master_burst.sv
// Bench for tdc_spi_master_burst: loopback, bursts, SPI modes,
// wide words, abort and mid-transfer reset.
module tb_tdc_spi_master_burst;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  logic       start0 = 1'b0;
  logic       hold0 = 1'b0;
  logic       abort0 = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic       sck0, mosi0, cs_n0, dv0, busy0;
  logic [7:0] dout0;

  tdc_spi_master_burst u0 (
    .clk(clk), .rst(rst), .start(start0),
    .data_in(din0), .cs_hold(hold0),
    .abort(abort0), .miso(mosi0),
    .sck(sck0), .mosi(mosi0), .cs_n(cs_n0),
    .data_out(dout0), .data_valid(dv0),
    .busy(busy0)
  );

  logic        start24 = 1'b0;
  logic [23:0] din24 = 24'h0;
  logic        sck24, mosi24, cs_n24, dv24, busy24;
  logic [23:0] dout24;

  tdc_spi_master_burst #(.DATA_W(24), .CLK_DIV(2)) u24 (
    .clk(clk), .rst(rst), .start(start24),
    .data_in(din24), .cs_hold(1'b0),
    .abort(1'b0), .miso(mosi24),
    .sck(sck24), .mosi(mosi24), .cs_n(cs_n24),
    .data_out(dout24), .data_valid(dv24),
    .busy(busy24)
  );

  logic       start_m = 1'b0;
  logic [7:0] din_m = 8'h00;
  logic [3:0] m_sck, m_busy, m_dv;
  logic [7:0] m_dout [4];
  logic [7:0] m_rcv [4];

  for (genvar g = 0; g < 4; g++) begin : gm
    localparam bit PL = (g / 2) == 1;
    localparam bit PH = (g % 2) == 1;
    logic       sck, mosi, cs_n, dv, busy;
    logic       miso = 1'b0;
    logic       ps = 1'b0;
    logic [7:0] dout;
    logic [7:0] sh = 8'h00;
    logic [7:0] rcv = 8'h00;

    tdc_spi_master_burst #(.CPOL(PL), .CPHA(PH)) u (
      .clk(clk), .rst(rst), .start(start_m),
      .data_in(din_m), .cs_hold(1'b0),
      .abort(1'b0), .miso(miso),
      .sck(sck), .mosi(mosi), .cs_n(cs_n),
      .data_out(dout), .data_valid(dv),
      .busy(busy)
    );

    assign m_sck[g]  = sck;
    assign m_busy[g] = busy;
    assign m_dv[g]   = dv;
    assign m_dout[g] = dout;
    assign m_rcv[g]  = rcv;

    // Slave returning 8'h3C: drives on its shift edge, samples on the other
    always @(cs_n, sck) begin
      if (cs_n !== 1'b0) begin
        sh = 8'h3C;
        miso = 1'b0;
        ps = sck;
        if (!PH) begin
          miso = sh[7];
          sh = sh << 1;
        end
      end else if (sck !== ps) begin
        ps = sck;
        if ((sck == PL) != PH) begin
          miso = sh[7];
          sh = sh << 1;
        end else begin
          rcv = {rcv[6:0], mosi};
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dv0 === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_dv: got pulse data %0h expected none",
               dout0);
      end
      if (sb.size() != 0) begin
        logic [7:0] e;
        e = sb.pop_front();
        checks++;
        assert (dout0 === e) else begin
          errors++;
          $error("FAIL sb_data: got %0h expected %0h", dout0, e);
        end
      end
    end
  end

  task automatic send0(input logic [7:0] d, input logic h,
                       output int nb, output int ncs,
                       output int nsck);
    logic ps;
    bit done;
    din0 = d;
    hold0 = h;
    start0 = 1'b1;
    ps = 1'b0;
    tick;
    start0 = 1'b0;
    nb = 0;
    ncs = 0;
    nsck = 0;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (sck0 && !ps) nsck++;
      ps = sck0;
      if (busy0) begin
        nb++;
        if (!cs_n0) ncs++;
        tick;
      end else begin
        done = 1;
      end
    end
    chk("send0_timeout", 32'(done), 1);
  endtask

  initial begin
    int nb, ncs, nsck, ndv, n;
    logic ps;
    bit done;
    int mdv [4];

    repeat (3) tick;
    chk("rst_cs_n", cs_n0, 1);
    chk("rst_sck", sck0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_dv", dv0, 0);
    chk("rst_busy", busy0, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("mode%0d_idle_sck", i), m_sck[i], i / 2);
    rst = 1'b1;
    tick;

    sb.push_back(8'hA5);
    send0(8'hA5, 1'b0, nb, ncs, nsck);
    chk("t1_busy", nb, 38);
    chk("t1_cs_low", ncs, 36);
    chk("t1_sck", nsck, 8);
    chk("t1_cs_end", cs_n0, 1);

    sb.push_back(8'h01);
    sb.push_back(8'h80);
    sb.push_back(8'hFF);
    send0(8'h01, 1'b1, nb, ncs, nsck);
    chk("t2w0_busy", nb, 34);
    chk("t2w0_cs", ncs, 34);
    chk("t2w0_sck", nsck, 8);
    chk("t2w0_cs_kept", cs_n0, 0);
    send0(8'h80, 1'b1, nb, ncs, nsck);
    chk("t2w1_busy_nosetup", nb, 32);
    chk("t2w1_cs", ncs, 32);
    chk("t2w1_cs_kept", cs_n0, 0);
    send0(8'hFF, 1'b0, nb, ncs, nsck);
    chk("t2w2_busy", nb, 36);
    chk("t2w2_cs", ncs, 34);
    chk("t2w2_cs_end", cs_n0, 1);

    din_m = 8'hC3;
    start_m = 1'b1;
    tick;
    start_m = 1'b0;
    for (int i = 0; i < 4; i++) mdv[i] = 0;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      for (int i = 0; i < 4; i++) mdv[i] += int'(m_dv[i]);
      if (m_busy == 4'b0000) done = 1;
      else tick;
    end
    chk("t3_timeout", 32'(done), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mode%0d_dout", i), m_dout[i], 8'h3C);
      chk($sformatf("mode%0d_mosi", i), m_rcv[i], 8'hC3);
      chk($sformatf("mode%0d_dv", i), mdv[i], 1);
      chk($sformatf("mode%0d_end_sck", i), m_sck[i], i / 2);
    end

    din24 = 24'h123456;
    start24 = 1'b1;
    ps = 1'b0;
    tick;
    start24 = 1'b0;
    nb = 0;
    nsck = 0;
    ndv = 0;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (sck24 && !ps) nsck++;
      ps = sck24;
      if (dv24) ndv++;
      if (busy24) begin
        nb++;
        tick;
      end else begin
        done = 1;
      end
    end
    chk("t4_timeout", 32'(done), 1);
    chk("t4_busy", nb, 54);
    chk("t4_sck", nsck, 24);
    chk("t4_dv", ndv, 1);
    chk("t4_dout", dout24, 24'h123456);

    din0 = 8'hA5;
    hold0 = 1'b0;
    start0 = 1'b1;
    ps = 1'b0;
    tick;
    start0 = 1'b0;
    n = 0;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (sck0 && !ps) n++;
      ps = sck0;
      if (n == 4) done = 1;
      else tick;
    end
    chk("t5_reach", 32'(done), 1);
    abort0 = 1'b1;
    tick;
    abort0 = 1'b0;
    chk("t5_sck_idle", sck0, 0);
    chk("t5_cs_a", cs_n0, 0);
    chk("t5_busy_a", busy0, 1);
    din0 = 8'h77;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("t5_cs_b", cs_n0, 0);
    tick;
    chk("t5_cs_c", cs_n0, 1);
    chk("t5_busy_c", busy0, 1);
    tick;
    chk("t5_busy_d", busy0, 1);
    tick;
    chk("t5_busy_e", busy0, 0);
    n = 0;
    ps = sck0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (sck0 && !ps) n++;
      ps = sck0;
    end
    chk("t5_no_sck", n, 0);
    chk("t5_cs_idle", cs_n0, 1);
    chk("t5_busy_idle", busy0, 0);
    chk("t5_dout_kept", dout0, 8'hFF);

    din0 = 8'h5A;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    repeat (10) tick;
    chk("t6_pre_busy", busy0, 1);
    rst = 1'b0;
    tick;
    chk("t6_cs_n", cs_n0, 1);
    chk("t6_sck", sck0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_dout", dout0, 0);
    chk("t6_dv", dv0, 0);
    chk("t6_mosi", mosi0, 0);
    rst = 1'b1;
    tick;
    sb.push_back(8'hA5);
    send0(8'hA5, 1'b0, nb, ncs, nsck);
    chk("t6_busy_after", nb, 38);
    chk("t6_sck_after", nsck, 8);

    repeat (2) tick;
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
